crypt_dispatch_ctrl: RTL and testbench
======================================

// Module: crypt_dispatch_ctrl
// PURPOSE
//  Parametrised request/response front end for the crypto subsystem. Accepts one ENC/DEC/PASSGEN job,
//  drives a shared engine bus with a start/done handshake, and enforces a timeout. Returns the tagged
//  result on a valid/ready port. Adds handshakes, error reporting and a status counter to the
//  mode-select top level. Sits between the host interface and the Encrypter/Decrypter/Password_Gen engines.
// PARAMETERS
//  PLAIN_W   60    plaintext/password width (DEC and PASSGEN result width)
//  CIPHER_W  78    ciphertext width; all data buses are CIPHER_W wide; must be >= PLAIN_W
//  TIMEOUT   64    max WAIT cycles for eng_done before a timeout error; legal range 2..2^16
//  CNT_W     16    width of the saturating status counters
// PORTS
//  Clk         in   1         clock, all logic on posedge
//  Rst_n       in   1         asynchronous active-low reset
//  req_valid   in   1         request present
//  req_ready   out  1         block can accept a request
//  req_mode    in   2         00 ENC, 01 DEC, 10 PASSGEN, 11 illegal
//  req_data    in   CIPHER_W  ENC: plaintext in [PLAIN_W-1:0], upper bits ignored; DEC: ciphertext; PASSGEN: ignored
//  eng_start   out  1         one-cycle start pulse to the engine
//  eng_sel     out  2         engine select, equals the captured mode
//  eng_data    out  CIPHER_W  captured operand, ENC upper bits forced to 0
//  eng_done    in   1         engine result valid (single-cycle)
//  eng_result  in   CIPHER_W  engine result
//  rsp_valid   out  1         response present
//  rsp_ready   in   1         consumer accepts response
//  rsp_mode    out  2         mode of the job being answered
//  rsp_data    out  CIPHER_W  result; for DEC/PASSGEN bits above PLAIN_W are forced to 0; 0 on error
//  rsp_err     out  2         00 ok, 01 illegal mode, 10 timeout
//  ok_cnt      out  CNT_W     completed-ok jobs, saturating
//  err_cnt     out  CNT_W     errored jobs, saturating
// BEHAVIOUR
//  Reset: all outputs 0, except req_ready, which is 1 (IDLE). FSM goes to IDLE. Any in-flight job is dropped.
//  FSM states are IDLE, START, WAIT, RESP. Only one job is in flight at a time.
//  IDLE: req_ready=1. On req_valid&req_ready, capture mode and data.
//    mode 11 -> RESP with rsp_err=01, rsp_data=0; the engine bus is untouched.
//    otherwise -> START.
//  START: eng_start=1 for exactly one cycle. eng_sel/eng_data become valid here and are held until
//    the state leaves WAIT. The WAIT counter is cleared. -> WAIT.
//  WAIT: eng_done is sampled each cycle and the counter increments.
//    eng_done=1 -> latch the result, apply the PLAIN_W mask for DEC/PASSGEN, rsp_err=00, -> RESP.
//    counter==TIMEOUT-1 with eng_done=0 -> rsp_err=10, rsp_data=0, -> RESP.
//    If eng_done=1 in the timeout cycle, done wins.
//  eng_done outside WAIT is ignored, including stale dones after a timeout.
//  RESP: rsp_valid=1; rsp_* are stable until rsp_valid&rsp_ready, then -> IDLE.
//  Counters: ok_cnt/err_cnt increment once, on the RESP handshake cycle; they saturate at all-ones.
//  Latency: accept at cycle N, eng_start at N+1, earliest eng_done at N+2, rsp_valid at N+3.
//    An illegal mode gives rsp_valid at N+1.
//  Back-to-back: a new request can be accepted the cycle after the RESP handshake.
//  Reset mid-job: takes effect immediately and asynchronously; eng_start deasserts; no response is issued.
// TESTING
//  ENC: req mode 00, data 60'h0AB_CDEF_0123_4567 -> eng_start 1 cycle later, eng_sel=00.
//    eng_done at N+2 with result 78'h3_FFFF_0000_1111_2222 -> rsp_valid at N+3, data matches, err 00, ok_cnt=1.
//  DEC masking: mode 01, eng_result all-ones -> rsp_data = 18'b0 followed by 60 ones, err 00.
//  Timeout: TIMEOUT=8, no eng_done -> rsp_err=10 and rsp_data=0 exactly 8 WAIT cycles after START.
//    A later stale eng_done is ignored; err_cnt=1.
//  Illegal mode 11 -> rsp_valid next cycle, err 01, eng_start never pulses.
//  Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout; accept resumes after the handshake.
//  Reset during WAIT: deassert Rst_n -> all outputs 0 and req_ready=1 with no clock edge needed; no response; counters 0.

Source files
------------

// File: rtl/crypt_dispatch_ctrl_if.sv
// Handshake and engine-bus bundle for crypt_dispatch_ctrl.
// The slave modport is the dispatcher's view. The master modport is the
// view of the host plus the engine pair it drives.
interface crypt_dispatch_ctrl_if #(
    parameter int CIPHER_W = 78
);
    // host request channel
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_mode;
    logic [CIPHER_W-1:0] req_data;

    // shared engine bus
    logic                eng_start;
    logic [1:0]          eng_sel;
    logic [CIPHER_W-1:0] eng_data;
    logic                eng_done;
    logic [CIPHER_W-1:0] eng_result;

    // response channel
    logic                rsp_valid;
    logic                rsp_ready;
    logic [1:0]          rsp_mode;
    logic [CIPHER_W-1:0] rsp_data;
    logic [1:0]          rsp_err;

    modport slave (
        input  req_valid, req_mode, req_data, eng_done, eng_result, rsp_ready,
        output req_ready, eng_start, eng_sel, eng_data,
               rsp_valid, rsp_mode, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_mode, req_data, eng_done, eng_result, rsp_ready,
        input  req_ready, eng_start, eng_sel, eng_data,
               rsp_valid, rsp_mode, rsp_data, rsp_err
    );
endinterface

// File: rtl/crypt_dispatch_ctrl.sv
// Single-job dispatcher for the crypto engines.
// It accepts an ENC, DEC or PASSGEN request and pulses start on the shared
// engine bus. It then waits for done, or gives up after TIMEOUT cycles, and
// returns a tagged, masked result on a valid/ready response port.
module crypt_dispatch_ctrl #(
    parameter int PLAIN_W  = 60,
    parameter int CIPHER_W = 78,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    crypt_dispatch_ctrl_if.slave bus,
    output logic [CNT_W-1:0]   ok_cnt,
    output logic [CNT_W-1:0]   err_cnt
);
    typedef enum logic [1:0] {
        MODE_ENC     = 2'b00,
        MODE_DEC     = 2'b01,
        MODE_PASSGEN = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    // Low PLAIN_W bits set. This masks ENC operands and DEC/PASSGEN results.
    localparam logic [CIPHER_W-1:0] PLAIN_MASK = ~({CIPHER_W{1'b1}} << PLAIN_W);
    // Wide enough to hold TIMEOUT-1; TIMEOUT=2 still needs one bit.
    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              state, next_state;
    mode_t               mode_q;
    logic [CIPHER_W-1:0] data_q;
    logic [CIPHER_W-1:0] rsp_data_q;
    err_t                rsp_err_q;
    logic [WAIT_W-1:0]   wait_cnt;

    logic accept;
    logic rsp_fire;
    logic timed_out;

    assign accept    = (state == IDLE) && bus.req_valid;
    assign rsp_fire  = (state == RESP) && bus.rsp_ready;
    assign timed_out = (wait_cnt == WAIT_LAST);

    // State register; reset drops any in-flight job immediately.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode and state-derived outputs.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_state    = state;
        bus.req_ready = 1'b0;
        bus.eng_start = 1'b0;
        bus.eng_sel   = 2'b00;
        bus.eng_data  = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_mode  = 2'b00;
        bus.rsp_data  = '0;
        bus.rsp_err   = 2'b00;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    next_state = (mode_t'(bus.req_mode) == MODE_ILLEGAL) ? RESP : START;
            end
            START: begin
                bus.eng_start = 1'b1;
                bus.eng_sel   = mode_q;
                bus.eng_data  = data_q;
                next_state    = WAIT;
            end
            WAIT: begin
                bus.eng_sel  = mode_q;
                bus.eng_data = data_q;
                if (bus.eng_done || timed_out) next_state = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_mode  = mode_q;
                bus.rsp_data  = rsp_data_q;
                bus.rsp_err   = rsp_err_q;
                if (bus.rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Job capture, wait counter and result/error latching.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mode_q     <= MODE_ENC;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= ERR_OK;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mode_q     <= mode_t'(bus.req_mode);
                    data_q     <= (mode_t'(bus.req_mode) == MODE_ENC) ? (bus.req_data & PLAIN_MASK)
                                                                     : bus.req_data;
                    rsp_data_q <= '0;
                    rsp_err_q  <= (mode_t'(bus.req_mode) == MODE_ILLEGAL) ? ERR_ILLEGAL : ERR_OK;
                end
                START: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // done beats timeout when both land in the same cycle
                    if (bus.eng_done) begin
                        rsp_data_q <= (mode_q == MODE_ENC) ? bus.eng_result
                                                           : (bus.eng_result & PLAIN_MASK);
                        rsp_err_q  <= ERR_OK;
                    end else if (timed_out) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating job counters, bumped only on the response handshake.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ok_cnt  <= '0;
            err_cnt <= '0;
        end else if (rsp_fire) begin
            if (rsp_err_q == ERR_OK) begin
                if (ok_cnt != '1) ok_cnt <= ok_cnt + 1'b1;
            end else begin
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_crypt_dispatch_ctrl.sv
// Directed bench for crypt_dispatch_ctrl (TIMEOUT=8).
// It covers an ENC job with latency, DEC masking, a timeout with a stale done,
// response backpressure, an illegal mode, back-to-back acceptance and a reset
// taken mid-job.
module tb_crypt_dispatch_ctrl;
    localparam int PLAIN_W  = 60;
    localparam int CIPHER_W = 78;
    localparam int TIMEOUT  = 8;
    localparam int CNT_W    = 16;

    logic             Clk;
    logic             Rst_n;
    logic [CNT_W-1:0] ok_cnt;
    logic [CNT_W-1:0] err_cnt;

    int total  = 0;
    int passed = 0;

    crypt_dispatch_ctrl_if #(.CIPHER_W(CIPHER_W)) bus ();

    crypt_dispatch_ctrl #(
        .PLAIN_W (PLAIN_W),
        .CIPHER_W(CIPHER_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .bus    (bus.slave),
        .ok_cnt (ok_cnt),
        .err_cnt(err_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock, then settle 1ns past the edge before sampling or driving.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [CIPHER_W-1:0] enc_in, enc_res, rsp_hold;

    initial begin
        enc_in  = {18'h3FFFF, 60'h0AB_CDEF_0123_4567};
        enc_res = 78'h3_FFFF_0000_1111_2222;

        Rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_mode   = 2'b00;
        bus.req_data   = '0;
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        bus.rsp_ready  = 1'b0;
        #12;
        check("reset_req_ready", bus.req_ready, 1'b1);
        check("reset_eng_start", bus.eng_start, 1'b0);
        check("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check("reset_rsp_data",  bus.rsp_data, '0);
        check("reset_ok_cnt",    ok_cnt, '0);
        check("reset_err_cnt",   err_cnt, '0);
        Rst_n = 1'b1;

        // ENC: upper operand bits must be dropped; latency N+1 start, N+3 rsp_valid.
        bus.req_valid = 1'b1;
        bus.req_mode  = 2'b00;
        bus.req_data  = enc_in;
        step();  // accept (N)
        bus.req_valid = 1'b0;
        check("enc_start",     bus.eng_start, 1'b1);
        check("enc_sel",       bus.eng_sel, 2'b00);
        check("enc_data",      bus.eng_data, 78'h0AB_CDEF_0123_4567);
        check("enc_req_ready", bus.req_ready, 1'b0);
        step();  // WAIT (N+2)
        check("enc_start_one", bus.eng_start, 1'b0);
        check("enc_data_hold", bus.eng_data, 78'h0AB_CDEF_0123_4567);
        check("enc_no_rsp",    bus.rsp_valid, 1'b0);
        bus.eng_done   = 1'b1;
        bus.eng_result = enc_res;
        step();  // RESP (N+3)
        bus.eng_done = 1'b0;
        check("enc_rsp_valid", bus.rsp_valid, 1'b1);
        check("enc_rsp_data",  bus.rsp_data, enc_res);
        check("enc_rsp_err",   bus.rsp_err, 2'b00);
        check("enc_rsp_mode",  bus.rsp_mode, 2'b00);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("enc_ok_cnt",   ok_cnt, 16'd1);
        check("enc_idle",     bus.req_ready, 1'b1);
        check("enc_rsp_done", bus.rsp_valid, 1'b0);

        // DEC: an all-ones result must be masked to the low 60 bits.
        bus.req_valid = 1'b1;
        bus.req_mode  = 2'b01;
        bus.req_data  = 78'h2A_5555_AAAA_5555_AAAA;
        step();
        bus.req_valid = 1'b0;
        check("dec_sel",  bus.eng_sel, 2'b01);
        check("dec_data", bus.eng_data, 78'h2A_5555_AAAA_5555_AAAA);
        step();
        bus.eng_done   = 1'b1;
        bus.eng_result = '1;
        step();
        bus.eng_done = 1'b0;
        check("dec_rsp_data", bus.rsp_data, {18'b0, {60{1'b1}}});
        check("dec_rsp_err",  bus.rsp_err, 2'b00);
        check("dec_rsp_mode", bus.rsp_mode, 2'b01);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("dec_ok_cnt", ok_cnt, 16'd2);

        // PASSGEN with no done: a timeout exactly 8 WAIT cycles after START.
        bus.req_valid = 1'b1;
        bus.req_mode  = 2'b10;
        step();  // START
        bus.req_valid = 1'b0;
        check("to_start", bus.eng_start, 1'b1);
        for (int i = 0; i < TIMEOUT; i++) step();  // WAIT cycles 0..7
        check("to_not_early", bus.rsp_valid, 1'b0);
        check("to_sel_held",  bus.eng_sel, 2'b10);
        step();  // RESP
        check("to_rsp_valid", bus.rsp_valid, 1'b1);
        check("to_rsp_err",   bus.rsp_err, 2'b10);
        check("to_rsp_data",  bus.rsp_data, '0);
        check("to_rsp_mode",  bus.rsp_mode, 2'b10);

        // Backpressure for 5 cycles; a stale done and a new request must both be ignored.
        rsp_hold       = bus.rsp_data;
        bus.eng_done   = 1'b1;
        bus.eng_result = '1;
        bus.req_valid  = 1'b1;
        bus.req_mode   = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rsp_valid", bus.rsp_valid, 1'b1);
            check("bp_rsp_err",   bus.rsp_err, 2'b10);
            check("bp_rsp_data",  bus.rsp_data, rsp_hold);
            check("bp_req_ready", bus.req_ready, 1'b0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("to_err_cnt", err_cnt, 16'd1);
        check("to_ok_cnt",  ok_cnt, 16'd2);
        step();  // stale done while IDLE
        bus.eng_done = 1'b0;
        check("stale_idle",  bus.req_ready, 1'b1);
        check("stale_start", bus.eng_start, 1'b0);
        check("stale_rsp",   bus.rsp_valid, 1'b0);

        // Illegal mode: the response comes the next cycle and the engine stays untouched.
        bus.req_valid = 1'b1;
        bus.req_mode  = 2'b11;
        bus.req_data  = '1;
        step();
        check("ill_rsp_valid", bus.rsp_valid, 1'b1);
        check("ill_rsp_err",   bus.rsp_err, 2'b01);
        check("ill_rsp_data",  bus.rsp_data, '0);
        check("ill_no_start",  bus.eng_start, 1'b0);
        check("ill_eng_data",  bus.eng_data, '0);
        // The next request is held valid across the handshake (back-to-back).
        bus.req_mode  = 2'b00;
        bus.req_data  = 78'h1234;
        bus.rsp_ready = 1'b1;
        step();  // handshake
        bus.rsp_ready = 1'b0;
        check("ill_err_cnt", err_cnt, 16'd2);
        check("b2b_ready",   bus.req_ready, 1'b1);
        step();  // accepted
        bus.req_valid = 1'b0;
        check("b2b_start", bus.eng_start, 1'b1);
        check("b2b_data",  bus.eng_data, 78'h1234);
        step();  // WAIT

        // Asynchronous reset during WAIT, sampled between clock edges.
        #2;
        Rst_n = 1'b0;
        #1;
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_eng_start", bus.eng_start, 1'b0);
        check("rst_eng_data",  bus.eng_data, '0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_ok_cnt",    ok_cnt, '0);
        check("rst_err_cnt",   err_cnt, '0);
        bus.eng_done   = 1'b1;
        bus.eng_result = '1;
        step();
        Rst_n        = 1'b1;
        bus.eng_done = 1'b0;
        step();
        step();
        check("rst_no_rsp", bus.rsp_valid, 1'b0);
        check("rst_idle",   bus.req_ready, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
